// File: rtl/otter_trap_ctrl_pkg.sv
// Shared trap-controller definitions: exception-select encodings, mcause mapping,
// FSM state type and interrupt cause base.
package otter_trap_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StTrap,
      StFlush,
      StRet
   } trap_state_e;

   localparam logic [3:0] MCAUSE_SEL_NONE                 = 4'd0;
   localparam logic [3:0] MCAUSE_SEL_INSTRN_ADDR_MISALIGN = 4'd1;
   localparam logic [3:0] MCAUSE_SEL_INVLD_INSTRN         = 4'd2;
   localparam logic [3:0] MCAUSE_SEL_EBREAK               = 4'd3;
   localparam logic [3:0] MCAUSE_SEL_LOAD_ADDR_MISALIGN   = 4'd4;
   localparam logic [3:0] MCAUSE_SEL_STORE_ADDR_MISALIGN  = 4'd5;

   localparam int unsigned IRQ_CAUSE_BASE = 16;
   localparam int unsigned IRQ_IDX_W      = 4;
   localparam int unsigned CNT_W          = 8;

   // Unrecognised non-zero selects are reported as an illegal instruction.
   function automatic logic [3:0] mcause_code(input logic [3:0] sel);
      logic [3:0] code;
      case (sel)
         MCAUSE_SEL_INSTRN_ADDR_MISALIGN: code = 4'd0;
         MCAUSE_SEL_INVLD_INSTRN:         code = 4'd2;
         MCAUSE_SEL_EBREAK:               code = 4'd3;
         MCAUSE_SEL_LOAD_ADDR_MISALIGN:   code = 4'd4;
         MCAUSE_SEL_STORE_ADDR_MISALIGN:  code = 4'd6;
         default:                         code = 4'd2;
      endcase
      return code;
   endfunction

endpackage

// File: rtl/otter_irq_prio.sv
// Interrupt input register/synchroniser plus masked lowest-index priority encoder.
// OTTER_TRAP_IRQ_SYNC_EN selects a 2-flop synchroniser instead of a single register.
module otter_irq_prio
   import otter_trap_ctrl_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 4
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [NUM_IRQ-1:0]   i_irq,
   input  logic [NUM_IRQ-1:0]   i_irq_mask,
   output logic [NUM_IRQ-1:0]   o_irq_pending,
   output logic                 o_irq_any,
   output logic [IRQ_IDX_W-1:0] o_irq_idx
);

   logic [NUM_IRQ-1:0] sync_q;

`ifdef OTTER_TRAP_IRQ_SYNC_EN
   logic [NUM_IRQ-1:0] meta_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= i_irq;
         sync_q <= meta_q;
      end
   end
`else
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= i_irq;
      end
   end
`endif

   assign o_irq_pending = sync_q & i_irq_mask;
   assign o_irq_any     = |o_irq_pending;

   // Scan downward so the lowest pending index is the last one written.
   always_comb begin
      o_irq_idx = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (o_irq_pending[i]) begin
            o_irq_idx = IRQ_IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/otter_trap_ctrl.sv
// Trap controller: captures exceptions/interrupts at instruction boundaries, hands them to
// the CSR file, then flushes. OTTER_TRAP_IRQ_SYNC_EN enables 2-flop interrupt synchronisation.
module otter_trap_ctrl
   import otter_trap_ctrl_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned NUM_IRQ     = 4,
   parameter int unsigned ACK_TIMEOUT = 15
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_instr_valid,
   input  logic [3:0]         i_excp_sel,
   input  logic [XLEN-1:0]    i_trap_mtval,
   input  logic [XLEN-1:0]    i_pc_addr,
   input  logic [XLEN-1:0]    i_pc_next,
   input  logic [NUM_IRQ-1:0] i_irq,
   input  logic [NUM_IRQ-1:0] i_irq_mask,
   input  logic               i_mie,
   input  logic               i_mret,
   input  logic               i_csr_ack,
   output logic               o_trap_req,
   output logic [XLEN-1:0]    o_trap_cause,
   output logic [XLEN-1:0]    o_trap_epc,
   output logic [XLEN-1:0]    o_trap_mtval,
   output logic               o_stall,
   output logic               o_flush,
   output logic               o_mret_req,
   output logic [NUM_IRQ-1:0] o_irq_pending,
   output logic               o_trap_err
);

   trap_state_e          state_q, state_d;
   logic [XLEN-1:0]      cause_q, cause_d;
   logic [XLEN-1:0]      epc_q, epc_d;
   logic [XLEN-1:0]      mtval_q, mtval_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 err_q, err_d;
   logic                 irq_any;
   logic [IRQ_IDX_W-1:0] irq_idx;

   otter_irq_prio #(
      .NUM_IRQ (NUM_IRQ)
   ) u_irq_prio (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_irq         (i_irq),
      .i_irq_mask    (i_irq_mask),
      .o_irq_pending (o_irq_pending),
      .o_irq_any     (irq_any),
      .o_irq_idx     (irq_idx)
   );

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      epc_d   = epc_q;
      mtval_d = mtval_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         StIdle: begin
            if (i_instr_valid) begin
               if (i_excp_sel != MCAUSE_SEL_NONE) begin
                  cause_d      = '0;
                  cause_d[3:0] = mcause_code(i_excp_sel);
                  epc_d        = i_pc_addr;
                  mtval_d      = i_trap_mtval;
                  cnt_d        = '0;
                  state_d      = StTrap;
               end else if (i_mie && irq_any) begin
                  cause_d            = '0;
                  cause_d[XLEN-1]    = 1'b1;
                  cause_d[4:0]       = 5'(IRQ_CAUSE_BASE) + {1'b0, irq_idx};
                  epc_d              = i_pc_next;
                  mtval_d            = '0;
                  cnt_d              = '0;
                  state_d            = StTrap;
               end else if (i_mret) begin
                  state_d = StRet;
               end
            end
         end
         StTrap: begin
            // An ack arriving on the timeout cycle still counts as a clean handoff.
            if (i_csr_ack) begin
               state_d = StFlush;
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = StFlush;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StFlush: state_d = StIdle;
         StRet:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= StIdle;
         cause_q <= '0;
         epc_q   <= '0;
         mtval_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         epc_q   <= epc_d;
         mtval_q <= mtval_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign o_trap_req   = (state_q == StTrap);
   assign o_flush      = (state_q == StFlush);
   assign o_stall      = (state_q == StTrap) || (state_q == StFlush);
   assign o_mret_req   = (state_q == StRet);
   assign o_trap_cause = cause_q;
   assign o_trap_epc   = epc_q;
   assign o_trap_mtval = mtval_q;
   assign o_trap_err   = err_q;

endmodule

// File: tb/tb_otter_trap_ctrl.sv
// Directed bench for otter_trap_ctrl: table of single-event vectors plus hand sequences
// for timeout, reset mid-trap and interrupt input latency.
module tb_otter_trap_ctrl;

   localparam int unsigned ACK_TO = 15;
`ifdef OTTER_TRAP_IRQ_SYNC_EN
   localparam int unsigned IRQ_LAG = 2;
`else
   localparam int unsigned IRQ_LAG = 1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid, mie, mret, csr_ack;
   logic [3:0]  excp_sel, irq, irq_mask;
   logic [31:0] trap_mtval, pc_addr, pc_next;
   logic        trap_req, stall, flush, mret_req, trap_err;
   logic [31:0] trap_cause, trap_epc, trap_mtval_o;
   logic [3:0]  irq_pending;

   always #5 clk = ~clk;

   otter_trap_ctrl #(
      .XLEN        (32),
      .NUM_IRQ     (4),
      .ACK_TIMEOUT (ACK_TO)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_instr_valid (instr_valid),
      .i_excp_sel    (excp_sel),
      .i_trap_mtval  (trap_mtval),
      .i_pc_addr     (pc_addr),
      .i_pc_next     (pc_next),
      .i_irq         (irq),
      .i_irq_mask    (irq_mask),
      .i_mie         (mie),
      .i_mret        (mret),
      .i_csr_ack     (csr_ack),
      .o_trap_req    (trap_req),
      .o_trap_cause  (trap_cause),
      .o_trap_epc    (trap_epc),
      .o_trap_mtval  (trap_mtval_o),
      .o_stall       (stall),
      .o_flush       (flush),
      .o_mret_req    (mret_req),
      .o_irq_pending (irq_pending),
      .o_trap_err    (trap_err)
   );

   typedef struct {
      logic        valid;
      logic [3:0]  sel;
      logic [31:0] pc;
      logic [31:0] pc_nx;
      logic [31:0] mtval;
      logic [3:0]  irq;
      logic [3:0]  mask;
      logic        mie;
      logic        mret;
      int          ack_dly;
      logic        exp_trap;
      logic        exp_ret;
      logic [31:0] exp_cause;
      logic [31:0] exp_epc;
      logic [31:0] exp_mtval;
   } vec_t;

   vec_t vecs[11];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_instr();
      instr_valid = 1'b0;
      excp_sel    = 4'd0;
      mret        = 1'b0;
      csr_ack     = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_trap_req"}, 32'(trap_req), 32'd0);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      check({tag, "_flush"}, 32'(flush), 32'd0);
      check({tag, "_mret_req"}, 32'(mret_req), 32'd0);
      check({tag, "_cause"}, trap_cause, 32'd0);
      check({tag, "_epc"}, trap_epc, 32'd0);
      check({tag, "_mtval"}, trap_mtval_o, 32'd0);
      check({tag, "_pending"}, 32'(irq_pending), 32'd0);
      check({tag, "_err"}, 32'(trap_err), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input logic exp_err);
      int ntrap;
      irq      = v.irq;
      irq_mask = v.mask;
      mie      = v.mie;
      repeat (3) tick();
      instr_valid = v.valid;
      excp_sel    = v.sel;
      pc_addr     = v.pc;
      pc_next     = v.pc_nx;
      trap_mtval  = v.mtval;
      mret        = v.mret;
      tick();
      clear_instr();
      // Garbage on the capture inputs must not disturb the held values.
      pc_addr    = '1;
      pc_next    = '1;
      trap_mtval = '1;
      if (v.exp_trap) begin
         check("trap_req", 32'(trap_req), 32'd1);
         check("trap_stall", 32'(stall), 32'd1);
         check("trap_mret_req", 32'(mret_req), 32'd0);
         check("cause", trap_cause, v.exp_cause);
         check("epc", trap_epc, v.exp_epc);
         check("mtval", trap_mtval_o, v.exp_mtval);
         ntrap = 1;
         for (int c = 0; c < v.ack_dly; c++) begin
            tick();
            if (trap_req) ntrap++;
         end
         csr_ack = 1'b1;
         tick();
         csr_ack = 1'b0;
         check("trap_cycles", 32'(ntrap), 32'(v.ack_dly + 1));
         check("flush_req_low", 32'(trap_req), 32'd0);
         check("flush", 32'(flush), 32'd1);
         check("flush_stall", 32'(stall), 32'd1);
         check("held_mtval", trap_mtval_o, v.exp_mtval);
         tick();
         check("idle_flush", 32'(flush), 32'd0);
         check("idle_stall", 32'(stall), 32'd0);
      end else if (v.exp_ret) begin
         check("ret_mret_req", 32'(mret_req), 32'd1);
         check("ret_stall", 32'(stall), 32'd0);
         check("ret_trap_req", 32'(trap_req), 32'd0);
         tick();
         check("ret_pulse_end", 32'(mret_req), 32'd0);
      end else begin
         check("none_trap_req", 32'(trap_req), 32'd0);
         check("none_mret_req", 32'(mret_req), 32'd0);
      end
      check("err", 32'(trap_err), 32'(exp_err));
      irq      = 4'd0;
      irq_mask = 4'd0;
      mie      = 1'b0;
   endtask

   initial begin
      int ntrap;
      int guard;
      // valid sel pc pc_next mtval irq mask mie mret ack trap ret cause epc mtval
      vecs[0]  = '{1'b1, 4'd4, 32'h100, 32'h104, 32'h203, 4'h0, 4'h0, 1'b0, 1'b0, 2,
                   1'b1, 1'b0, 32'd4, 32'h100, 32'h203};
      vecs[1]  = '{1'b1, 4'd0, 32'h200, 32'h204, 32'hdead, 4'b1010, 4'b1111, 1'b1, 1'b0, 0,
                   1'b1, 1'b0, 32'h8000_0011, 32'h204, 32'h0};
      vecs[2]  = '{1'b1, 4'd3, 32'h300, 32'h304, 32'h55, 4'b0001, 4'b1111, 1'b1, 1'b1, 1,
                   1'b1, 1'b0, 32'd3, 32'h300, 32'h55};
      vecs[3]  = '{1'b1, 4'd0, 32'h40, 32'h44, 32'h9, 4'b0110, 4'b0100, 1'b1, 1'b0, 0,
                   1'b1, 1'b0, 32'h8000_0012, 32'h44, 32'h0};
      vecs[4]  = '{1'b1, 4'd0, 32'h500, 32'h504, 32'h0, 4'b1111, 4'b1111, 1'b0, 1'b1, 0,
                   1'b0, 1'b1, 32'h0, 32'h0, 32'h0};
      vecs[5]  = '{1'b1, 4'd1, 32'h601, 32'h605, 32'h601, 4'h0, 4'h0, 1'b0, 1'b0, 0,
                   1'b1, 1'b0, 32'd0, 32'h601, 32'h601};
      vecs[6]  = '{1'b1, 4'd2, 32'h700, 32'h704, 32'h13, 4'h0, 4'h0, 1'b0, 1'b0, 14,
                   1'b1, 1'b0, 32'd2, 32'h700, 32'h13};
      vecs[7]  = '{1'b1, 4'd5, 32'h800, 32'h804, 32'h803, 4'h0, 4'h0, 1'b0, 1'b0, 13,
                   1'b1, 1'b0, 32'd6, 32'h800, 32'h803};
      vecs[8]  = '{1'b1, 4'd0, 32'h900, 32'h904, 32'h0, 4'b1000, 4'b1111, 1'b1, 1'b1, 0,
                   1'b1, 1'b0, 32'h8000_0013, 32'h904, 32'h0};
      vecs[9]  = '{1'b0, 4'd4, 32'ha00, 32'ha04, 32'h1, 4'b0001, 4'b1111, 1'b1, 1'b1, 0,
                   1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
      vecs[10] = '{1'b1, 4'd0, 32'hb00, 32'hb04, 32'h0, 4'b1111, 4'b0000, 1'b1, 1'b0, 0,
                   1'b0, 1'b0, 32'h0, 32'h0, 32'h0};

      rst_n = 1'b0;
      clear_instr();
      irq        = 4'd0;
      irq_mask   = 4'd0;
      mie        = 1'b0;
      pc_addr    = '0;
      pc_next    = '0;
      trap_mtval = '0;
      #3;
      check_all_zero("reset");
      tick();
      tick();
      rst_n = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i], 1'b0);
      end

      // Interrupt input latency.
      irq_mask = 4'b0001;
      repeat (3) tick();
      irq = 4'b0001;
      tick();
      check("irq_lag_1", 32'(irq_pending), (IRQ_LAG == 1) ? 32'd1 : 32'd0);
      tick();
      check("irq_lag_2", 32'(irq_pending), 32'd1);
      irq      = 4'd0;
      irq_mask = 4'd0;
      repeat (3) tick();

      // Ack never arrives: timeout after ACK_TO trap cycles.
      instr_valid = 1'b1;
      excp_sel    = 4'd2;
      pc_addr     = 32'hc00;
      trap_mtval  = 32'hc0;
      tick();
      clear_instr();
      ntrap = 0;
      guard = 0;
      while (trap_req === 1'b1 && guard < 40) begin
         ntrap++;
         if (ntrap == int'(ACK_TO)) check("to_err_before", 32'(trap_err), 32'd0);
         tick();
         guard++;
      end
      check("to_trap_cycles", 32'(ntrap), 32'(ACK_TO));
      check("to_flush", 32'(flush), 32'd1);
      check("to_err", 32'(trap_err), 32'd1);
      tick();
      check("to_idle_stall", 32'(stall), 32'd0);
      check("to_err_sticky", 32'(trap_err), 32'd1);
      run_vec(vecs[5], 1'b1);

      // Reset asserted in the middle of a trap.
      instr_valid = 1'b1;
      excp_sel    = 4'd4;
      pc_addr     = 32'hd00;
      trap_mtval  = 32'hd1;
      irq         = 4'b0001;
      irq_mask    = 4'b0001;
      tick();
      clear_instr();
      check("pre_rst_trap_req", 32'(trap_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check_all_zero("rst_mid_trap");
      tick();
      rst_n    = 1'b1;
      irq      = 4'd0;
      irq_mask = 4'd0;
      run_vec(vecs[0], 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
